// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit.
//   - mau_state_e  : access FSM states (idle, request outstanding, completion)
//   - DefAddrWidth : default byte-address width
//   - DefDataWidth : default data word width
//   - AlignMask    : address LSBs that must be zero for a word access
//   - is_aligned() : word-alignment test on the two address LSBs
package mem_access_unit_pkg;

   localparam int unsigned DefAddrWidth = 32;
   localparam int unsigned DefDataWidth = 32;
   localparam logic [1:0]  AlignMask    = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StDone
   } mau_state_e;

   function automatic logic is_aligned(input logic [1:0] addr_lsb);
      return (addr_lsb & AlignMask) == 2'b00;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the access unit (master) and the memory (slave).
//   req   : request, held until ack or abandon
//   we    : 1 = write, 0 = read
//   addr  : byte address
//   wdata : store data
//   ack   : single-cycle completion from memory
//   rdata : read data, valid with ack
interface mem_access_unit_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  req;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  ack;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (
      output req,
      output we,
      output addr,
      output wdata,
      input  ack,
      input  rdata
   );

   modport slave (
      input  req,
      input  we,
      input  addr,
      input  wdata,
      output ack,
      output rdata
   );
endinterface

// File: rtl/mem_timeout_counter.sv
// Counts cycles spent waiting for a bus acknowledge.
//   clk, reset : clock, asynchronous active-high reset
//   clear_i    : synchronous clear (has priority over enable_i)
//   enable_i   : count this cycle
//   tc_o       : this enabled cycle is the TIMEOUT_CYCLES-th one
module mem_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic tc_o
);

   // Count value during the first waiting cycle is 0, so the terminal
   // cycle is the one where the count equals TIMEOUT_CYCLES - 1.
   localparam logic [7:0] TermCnt = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] cnt_q, cnt_d;

   assign tc_o = enable_i && (cnt_q == TermCnt);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && !tc_o) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit. Turns load/store requests from the
// EX/MEM register into a req/ack bus transaction, stalls the pipeline while
// it is outstanding, returns load data and flags misalignment and timeouts.
//   clk, reset    : clock, asynchronous active-high reset
//   i_mem_read    : load in MEM stage
//   i_mem_write   : store in MEM stage (wins if both set)
//   i_alu_result  : access byte address
//   i_data_2      : store data
//   o_stall       : freeze upstream stages (combinational)
//   o_read_data   : last completed load data
//   o_read_valid  : pulse, o_read_data updated this cycle
//   o_misaligned  : pulse, misaligned access dropped
//   o_bus_timeout : pulse, transaction abandoned
//   bus           : data-memory bus, master side
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = DefAddrWidth,
   parameter int unsigned DATA_WIDTH     = DefDataWidth,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_mem_read,
   input  logic                  i_mem_write,
   input  logic [ADDR_WIDTH-1:0] i_alu_result,
   input  logic [DATA_WIDTH-1:0] i_data_2,
   output logic                  o_stall,
   output logic [DATA_WIDTH-1:0] o_read_data,
   output logic                  o_read_valid,
   output logic                  o_misaligned,
   output logic                  o_bus_timeout,
   mem_access_unit_if.master     bus
);

   mau_state_e state_q, state_d;

   logic                  req_q, req_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rvalid_q, rvalid_d;
   logic                  mis_q, mis_d;
   logic                  tout_q, tout_d;

   logic access, aligned, stall;
   logic cnt_clr, cnt_en, cnt_tc;

   assign access  = i_mem_read | i_mem_write;
   assign aligned = is_aligned(i_alu_result[1:0]);

   mem_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear_i (cnt_clr),
      .enable_i(cnt_en),
      .tc_o    (cnt_tc)
   );

   always_comb begin
      state_d  = state_q;
      req_d    = 1'b0;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      mis_d    = 1'b0;
      tout_d   = 1'b0;
      cnt_clr  = 1'b0;
      cnt_en   = 1'b0;
      stall    = 1'b0;

      unique case (state_q)
         StIdle: begin
            cnt_clr = 1'b1;
            if (access) begin
               if (aligned) begin
                  stall   = 1'b1;
                  addr_d  = i_alu_result;
                  wdata_d = i_data_2;
                  we_d    = i_mem_write;
                  req_d   = 1'b1;
                  state_d = StReq;
               end else begin
                  mis_d = 1'b1;
               end
            end
         end
         StReq: begin
            stall  = 1'b1;
            cnt_en = 1'b1;
            if (bus.ack) begin
               // Ack beats a coincident terminal count.
               if (!we_q) begin
                  rdata_d  = bus.rdata;
                  rvalid_d = 1'b1;
               end
               state_d = StDone;
            end else if (cnt_tc) begin
               tout_d = 1'b1;
               if (!we_q) begin
                  rdata_d  = '0;
                  rvalid_d = 1'b1;
               end
               state_d = StDone;
            end else begin
               req_d = 1'b1;
            end
         end
         StDone: begin
            cnt_clr = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         mis_q    <= 1'b0;
         tout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         mis_q    <= mis_d;
         tout_q   <= tout_d;
      end
   end

   // Stall is the only combinational output; force it low while in reset so
   // every output reads zero immediately.
   assign o_stall       = stall & ~reset;
   assign o_read_data   = rdata_q;
   assign o_read_valid  = rvalid_q;
   assign o_misaligned  = mis_q;
   assign o_bus_timeout = tout_q;

   assign bus.req   = req_q;
   assign bus.we    = we_q;
   assign bus.addr  = addr_q;
   assign bus.wdata = wdata_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit of the pipelined CPU: consumes the memory control, address and store-data fields presented by the EX/MEM pipeline register and turns them into a request/acknowledge transaction on the data-memory bus. It stalls the pipeline while a transaction is outstanding, returns load data toward the MEM/WB register, and flags misaligned accesses and bus timeouts.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width
- DATA_WIDTH, 32, data word width
- TIMEOUT_CYCLES, 255, max REQ cycles without ack before timeout (1..255)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; all state and outputs cleared immediately
- i_mem_read  in  1  load in MEM stage
- i_mem_write  in  1  store in MEM stage
- i_alu_result  in  ADDR_WIDTH  access byte address
- i_data_2  in  DATA_WIDTH  store data
- o_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM; bubble into MEM/WB
- o_read_data  out  DATA_WIDTH  last completed load data
- o_read_valid  out  1  one-cycle pulse: o_read_data updated this cycle
- o_misaligned  out  1  one-cycle pulse: access with address[1:0] != 0 dropped
- o_bus_timeout  out  1  one-cycle pulse: transaction abandoned
- o_bus_req  out  1  request, held until ack or timeout
- o_bus_we  out  1  1 = write, 0 = read
- o_bus_addr  out  ADDR_WIDTH  captured address
- o_bus_wdata  out  DATA_WIDTH  captured store data
- i_bus_ack  in  1  memory completion, single-cycle
- i_bus_rdata  in  DATA_WIDTH  read data, valid with i_bus_ack

## Operation
- States: IDLE, REQ, DONE.
- IDLE: access = i_mem_read | i_mem_write.
  - access, aligned: o_stall=1 combinationally this cycle; capture address, data, we (i_mem_write has priority if both set); next REQ.
  - access, misaligned: no stall, no request; o_misaligned pulses next cycle; stay IDLE.
  - no access: o_stall=0, stay IDLE. i_bus_ack ignored.
- REQ: o_bus_req=1, o_stall=1, bus address/data/we stable. Timeout counter increments each REQ cycle.
  - i_bus_ack: if read, register i_bus_rdata into o_read_data; -> DONE.
  - no ack and counter reaches TIMEOUT_CYCLES: -> DONE, o_bus_timeout pulses in DONE; a read loads o_read_data=0.
  - ack in the same cycle as timeout: ack wins, no timeout pulse.
- DONE: o_stall=0, o_bus_req=0; o_read_valid=1 for completed reads (including timed-out reads); pipeline advances at end of this cycle; -> IDLE unconditionally. Counter cleared.
- o_read_data holds until the next completed read.
- Back-to-back accesses: instruction arriving in MEM after DONE is detected in the following IDLE cycle; no lost or duplicated transaction.

## Timing
- Reset values: state IDLE; o_stall, o_read_valid, o_misaligned, o_bus_timeout, o_bus_req, o_bus_we = 0; o_read_data, o_bus_addr, o_bus_wdata = 0; counter 0.
- Reset mid-REQ: o_bus_req drops immediately; a subsequent late ack is ignored.
- Zero-wait memory (ack in first REQ cycle): stall high for 2 cycles (IDLE-detect, REQ), low in DONE; MEM occupancy 3 cycles.
- N-cycle ack latency: stall 1 + N cycles.
- Timeout: o_bus_req high exactly TIMEOUT_CYCLES cycles, then DONE.
- All outputs except o_stall are registered; o_stall is combinational from state and IDLE-cycle access decode.

## Structure
- Shared package: state enumeration (IDLE/REQ/DONE), ADDR_WIDTH/DATA_WIDTH defaults, alignment mask constant.
- One sub-module: mem_timeout_counter (clear, enable, terminal-count output, parameter TIMEOUT_CYCLES).

## Test plan
- Load 0x0000_0010, ack in first REQ cycle with rdata 0xDEAD_BEEF -> stall 2 cycles, o_read_valid pulse in DONE, o_read_data=0xDEAD_BEEF.
- Store 0x1234_5678 to 0x0000_0020, ack after 3 cycles -> o_bus_we=1, addr/wdata stable 3 cycles, stall 4 cycles, no o_read_valid.
- Load to 0x0000_0013 -> no o_bus_req, no stall, o_misaligned single pulse.
- TIMEOUT_CYCLES=4, load, never ack -> o_bus_req high 4 cycles, o_bus_timeout pulse, o_read_data=0, pipeline released.
- Ack coincident with terminal count -> data captured, no timeout pulse.
- reset asserted in REQ, then ack one cycle after release -> outputs zero immediately, state IDLE, late ack ignored, no o_read_valid.
